// File: rtl/tetris_pkg.sv
// Shared types and helpers for the 8x8 falling-block game controller.
// The frame type is also consumed by the LED matrix driver.
package tetris_pkg;

    typedef enum logic [2:0] {
        SPAWN = 3'd0,
        FALL  = 3'd1,
        DROP  = 3'd2,
        LOCK  = 3'd3,
        CLEAR = 3'd4,
        OVER  = 3'd5
    } ctrl_state_t;

    localparam int         ROWS     = 8;
    localparam int         COLS     = 8;
    localparam logic [7:0] ROW_FULL = 8'hFF;

    typedef logic [7:0][7:0] frame_t;

    // Two-cell horizontal bar whose lower (rightmost) bit sits at column x.
    function automatic logic [7:0] piece_mask(input logic [2:0] x);
        return 8'b0000_0011 << x;
    endfunction

    // Frame containing only the piece at the given row and column.
    function automatic frame_t piece_frame(input logic [2:0] row, input logic [2:0] x);
        frame_t f;
        f      = '0;
        f[row] = piece_mask(x);
        return f;
    endfunction

endpackage

// File: rtl/board_row_clear.sv
// Combinational row-clear helper: reports whether the given row is full and
// produces the board with that row removed and everything above shifted down.
module board_row_clear
    import tetris_pkg::*;
(
    input  frame_t     board,
    input  logic [2:0] row,
    output frame_t     shifted,
    output logic       full
);

    logic [63:0] keep_s;

    // Rows below the cleared one are kept; rows at/above take the row above them.
    always_comb begin
        keep_s  = (64'd1 << {row, 3'b000}) - 64'd1;
        shifted = (board & keep_s) | ((board >> 8) & ~keep_s);
        full    = (board[row] == ROW_FULL);
    end

endmodule

// File: rtl/tetris_board_ctrl.sv
// Game-state controller for the 8x8 playfield: spawn, move, gravity, hard
// drop, lock, row clear and game over; drives red/green LED frames.
module tetris_board_ctrl
    import tetris_pkg::*;
#(
    parameter int SPAWN_X = 3,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               left,
    input  logic               right,
    input  logic               drop,
    output frame_t             red_array,
    output frame_t             green_array,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    localparam logic [2:0]         SPAWN_COL = 3'(SPAWN_X);
    localparam logic [2:0]         TOP_ROW   = 3'd7;
    localparam logic [2:0]         MAX_X     = 3'd6;
    localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    ctrl_state_t        state_r;
    logic [2:0]         row_r;
    logic [2:0]         x_r;
    frame_t             board_r;
    logic [SCORE_W-1:0] score_r;

    logic [7:0]         mask_s;
    logic [2:0]         row_below_s;
    logic [2:0]         x_left_s;
    logic [2:0]         x_right_s;
    logic               hit_below_s;
    logic               can_left_s;
    logic               can_right_s;
    logic               spawn_hit_s;
    logic               left_only_s;
    logic               right_only_s;
    logic [SCORE_W-1:0] score_next_s;
    frame_t             cleared_s;
    logic               full_s;

    board_row_clear u_row_clear (
        .board   (board_r),
        .row     (row_r),
        .shifted (cleared_s),
        .full    (full_s)
    );

    // Collision and move-legality decisions for the current piece position.
    always_comb begin
        mask_s       = piece_mask(x_r);
        row_below_s  = row_r - 3'd1;
        x_left_s     = x_r + 3'd1;
        x_right_s    = x_r - 3'd1;
        hit_below_s  = (row_r == 3'd0) || ((board_r[row_below_s] & mask_s) != 8'h00);
        can_left_s   = (x_r < MAX_X) && ((board_r[row_r] & (mask_s << 3'd1)) == 8'h00);
        can_right_s  = (x_r > 3'd0) && ((board_r[row_r] & (mask_s >> 3'd1)) == 8'h00);
        spawn_hit_s  = ((board_r[TOP_ROW] & piece_mask(SPAWN_COL)) != 8'h00);
        left_only_s  = left && !right;
        right_only_s = right && !left;
        score_next_s = (score_r == SCORE_MAX) ? score_r : score_r + SCORE_ONE;
    end

    // Main FSM; green frame is updated together with the piece position so it always matches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= SPAWN;
            row_r       <= TOP_ROW;
            x_r         <= SPAWN_COL;
            board_r     <= '0;
            score_r     <= '0;
            green_array <= '0;
            game_over   <= 1'b0;
        end else begin
            case (state_r)
                SPAWN: begin
                    row_r <= TOP_ROW;
                    x_r   <= SPAWN_COL;
                    if (spawn_hit_s) begin
                        state_r     <= OVER;
                        green_array <= '0;
                        game_over   <= 1'b1;
                    end else begin
                        state_r     <= FALL;
                        green_array <= piece_frame(TOP_ROW, SPAWN_COL);
                    end
                end
                FALL: begin
                    if (drop) begin
                        state_r <= DROP;
                    end else if (tick) begin
                        if (hit_below_s) begin
                            state_r     <= LOCK;
                            green_array <= '0;
                        end else begin
                            row_r       <= row_below_s;
                            green_array <= piece_frame(row_below_s, x_r);
                        end
                    end else if (left_only_s && can_left_s) begin
                        x_r         <= x_left_s;
                        green_array <= piece_frame(row_r, x_left_s);
                    end else if (right_only_s && can_right_s) begin
                        x_r         <= x_right_s;
                        green_array <= piece_frame(row_r, x_right_s);
                    end else begin
                        state_r <= FALL;
                    end
                end
                DROP: begin
                    if (hit_below_s) begin
                        state_r     <= LOCK;
                        green_array <= '0;
                    end else begin
                        row_r       <= row_below_s;
                        green_array <= piece_frame(row_below_s, x_r);
                    end
                end
                LOCK: begin
                    board_r[row_r] <= board_r[row_r] | mask_s;
                    green_array    <= '0;
                    state_r        <= CLEAR;
                end
                CLEAR: begin
                    // Only the row just locked can have become full.
                    if (full_s) begin
                        board_r <= cleared_s;
                        score_r <= score_next_s;
                    end else begin
                        board_r <= board_r;
                    end
                    state_r <= SPAWN;
                end
                OVER: begin
                    green_array <= '0;
                    game_over   <= 1'b1;
                end
                default: begin
                    state_r     <= SPAWN;
                    green_array <= '0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

    assign red_array = board_r;
    assign score     = score_r;

endmodule

// File: tb/tb_tetris_board_ctrl.sv
// Scoreboard bench for tetris_board_ctrl: directed game scenarios followed by
// random play, checked every cycle against a behavioural game model.
module tb_tetris_board_ctrl;
    import tetris_pkg::*;

    localparam int SPAWN_X = 3;
    localparam int M_SPAWN = 0, M_FALL = 1, M_DROP = 2, M_LOCK = 3, M_CLEAR = 4, M_OVER = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1, tick = 1'b0, left = 1'b0, right = 1'b0, drop = 1'b0;
    frame_t     red_array, green_array;
    logic       game_over;
    logic [7:0] score;

    typedef struct {
        frame_t     red;
        frame_t     green;
        logic       go;
        logic [7:0] sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Game model: phase, piece position, board rows as integers, score.
    int ms = M_SPAWN, mrow = 7, mx = SPAWN_X, msc = 0;
    int mb[8];
    int over_cnt = 0;

    tetris_board_ctrl #(.SPAWN_X(SPAWN_X), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .left(left), .right(right), .drop(drop),
        .red_array(red_array), .green_array(green_array), .game_over(game_over), .score(score)
    );

    initial forever #5 clk = ~clk;

    function automatic int pm(int x);
        return (3 << x) & 255;
    endfunction

    function automatic bit blocked();
        if (mrow == 0) return 1'b1;
        return (mb[mrow-1] & pm(mx)) != 0;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit l, input bit rt, input bit d);
        if (r) begin
            ms = M_SPAWN; mrow = 7; mx = SPAWN_X; msc = 0;
            for (int i = 0; i < 8; i++) mb[i] = 0;
        end else begin
            case (ms)
                M_SPAWN: begin
                    mrow = 7; mx = SPAWN_X;
                    ms = ((mb[7] & pm(mx)) != 0) ? M_OVER : M_FALL;
                end
                M_FALL: begin
                    if (d) ms = M_DROP;
                    else if (t) begin
                        if (blocked()) ms = M_LOCK; else mrow = mrow - 1;
                    end else if (l && !rt) begin
                        if (mx < 6 && (mb[mrow] & (pm(mx) << 1)) == 0) mx = mx + 1;
                    end else if (rt && !l) begin
                        if (mx > 0 && (mb[mrow] & (pm(mx) >> 1)) == 0) mx = mx - 1;
                    end
                end
                M_DROP: if (blocked()) ms = M_LOCK; else mrow = mrow - 1;
                M_LOCK: begin
                    mb[mrow] = mb[mrow] | pm(mx);
                    ms = M_CLEAR;
                end
                M_CLEAR: begin
                    if (mb[mrow] == 255) begin
                        for (int i = mrow; i < 7; i++) mb[i] = mb[i+1];
                        mb[7] = 0;
                        if (msc < 255) msc = msc + 1;
                    end
                    ms = M_SPAWN;
                end
                default: ;
            endcase
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.green = '0;
        for (int r = 0; r < 8; r++) e.red[r] = 8'(mb[r]);
        if (ms == M_FALL || ms == M_DROP) e.green[3'(mrow)] = 8'(pm(mx));
        e.go = (ms == M_OVER);
        e.sc = 8'(msc);
        q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit t, input bit l, input bit rt, input bit d);
        @(negedge clk);
        reset = r; tick = t; left = l; right = rt; drop = d;
        model_step(r, t, l, rt, d);
        push_exp();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_fall();
        for (int i = 0; i < 40 && ms != M_FALL && ms != M_OVER; i++) idle(1);
    endtask

    // Move a fresh piece from the spawn column to target_x and hard-drop it.
    task automatic place(input int target_x);
        wait_fall();
        if (ms == M_FALL) begin
            for (int i = SPAWN_X; i < target_x; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            for (int i = SPAWN_X; i > target_x; i--) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            wait_fall();
        end
    endtask

    // Monitor: compare every registered output one step after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (red_array !== e.red) begin
                    errors++;
                    $display("FAIL red_array: got %h expected %h at %0t", red_array, e.red, $time);
                end
                checks++;
                if (green_array !== e.green) begin
                    errors++;
                    $display("FAIL green_array: got %h expected %h at %0t", green_array, e.green, $time);
                end
                checks++;
                if (game_over !== e.go) begin
                    errors++;
                    $display("FAIL game_over: got %b expected %b at %0t", game_over, e.go, $time);
                end
                checks++;
                if (score !== e.sc) begin
                    errors++;
                    $display("FAIL score: got %0d expected %0d at %0t", score, e.sc, $time);
                end
            end
        end
    end

    initial begin
        bit r, t, l, rt, d;
        for (int i = 0; i < 8; i++) mb[i] = 0;
        // Reset and spawn at the default column.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Walk left past the wall, then simultaneous left/right.
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        // Hard drop on the empty board.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_fall();
        idle(1);
        // Fill row 0 with a row above it, forcing a clear.
        place(6);
        place(0);
        place(4);
        place(2);
        idle(2);
        // Stack at the spawn column until the spawn collides.
        repeat (9) place(3);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Tick and left together, then reset in the middle of a drop.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        // Random play with periodic restarts after game over.
        for (int n = 0; n < 4000; n++) begin
            over_cnt = (ms == M_OVER) ? over_cnt + 1 : 0;
            r  = (over_cnt > 8) || ($urandom % 1000 == 0);
            t  = ($urandom % 5 == 0);
            l  = ($urandom % 4 == 0);
            rt = ($urandom % 4 == 0);
            d  = ($urandom % 30 == 0);
            cyc(r, t, l, rt, d);
        end
        idle(2);
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
